// File: rtl/tia_beam_ctrl.sv
// Beam scheduler for the TIA video path: paces horizontal/vertical beam
// steps against the LCD writer, issues pixel strobes with blanking, and
// sequences the WSYNC CPU stall and the VSYNC frame restart.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | after reset, waits for the LCD writer to go idle
// RUN   | normal beam pacing; steps when pace_cnt reaches PACE
// SYNC  | one-cycle frame restart after VSYNC, then back to RUN
module tia_beam_ctrl #(
    parameter int unsigned H_TOTAL   = 456,
    parameter int unsigned H_VISIBLE = 320,
    parameter int unsigned V_TOTAL   = 262,
    parameter int unsigned V_VISIBLE = 240,
    parameter int unsigned V_TOP     = 24,
    parameter int unsigned V_BOTTOM  = 226,
    parameter logic [7:0]  PACE      = 8'd255,
    parameter int unsigned HREL_X    = 319
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wsync_i,
    input  logic       vsync_i,
    input  logic       lcd_busy_i,
    output logic [8:0] xpos_o,
    output logic [8:0] ypos_o,
    output logic [8:0] pix_x_o,
    output logic [8:0] pix_y_o,
    output logic       pix_stb_o,
    output logic       pix_blank_o,
    output logic       cursor_rst_o,
    output logic       frame_o,
    output logic       stall_cpu_o
);

    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_VIS   = 9'(H_VISIBLE);
    localparam logic [8:0] V_VIS   = 9'(V_VISIBLE);
    localparam logic [8:0] V_TOP9  = 9'(V_TOP);
    localparam logic [8:0] V_BOT9  = 9'(V_BOTTOM);
    localparam logic [8:0] H_REL9  = 9'(HREL_X);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pace_q, pace_d;
    logic [8:0] x_q, y_q;
    logic       step;
    logic       sync_go;
    logic       pix_vis;
    logic       pix_blk;
    logic       x_wrap;
    logic       y_wrap;

    assign x_wrap  = (x_q == H_LAST);
    assign y_wrap  = (y_q == V_LAST);
    assign pix_vis = (x_q < H_VIS) && (y_q < V_VIS);
    assign pix_blk = (y_q < V_TOP9) || (y_q >= V_BOT9);

    assign xpos_o = x_q;
    assign ypos_o = y_q;

    // State register and pace counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            pace_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pace_q  <= pace_d;
        end
    end

    // Next state, pace counting and step decision; VSYNC outranks a step
    always_comb begin
        state_d = state_q;
        pace_d  = pace_q;
        step    = 1'b0;
        sync_go = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (vsync_i) begin
                    state_d = ST_SYNC;
                    sync_go = 1'b1;
                    pace_d  = 8'd0;
                end else if (!lcd_busy_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (vsync_i) begin
                    state_d = ST_SYNC;
                    sync_go = 1'b1;
                    pace_d  = 8'd0;
                end else if (pace_q == PACE) begin
                    if (!lcd_busy_i) begin
                        step   = 1'b1;
                        pace_d = 8'd0;
                    end
                end else begin
                    pace_d = pace_q + 8'd1;
                end
            end
            ST_SYNC: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                pace_d  = 8'd0;
            end
        endcase
    end

    // Beam counters: restart on VSYNC, advance one position per step
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= 9'd0;
            y_q <= 9'd0;
        end else if (sync_go) begin
            x_q <= 9'd0;
            y_q <= 9'd0;
        end else if (step) begin
            if (x_wrap) begin
                x_q <= 9'd0;
                y_q <= y_wrap ? 9'd0 : y_q + 9'd1;
            end else begin
                x_q <= x_q + 9'd1;
            end
        end
    end

    // Pixel strobe, frame/cursor pulses and the WSYNC stall (a new WSYNC beats a release)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_stb_o    <= 1'b0;
            pix_blank_o  <= 1'b0;
            pix_x_o      <= 9'd0;
            pix_y_o      <= 9'd0;
            frame_o      <= 1'b0;
            cursor_rst_o <= 1'b0;
            stall_cpu_o  <= 1'b0;
        end else begin
            pix_stb_o    <= step && pix_vis;
            pix_blank_o  <= step && pix_vis && pix_blk;
            if (step && pix_vis) begin
                pix_x_o <= x_q;
                pix_y_o <= y_q;
            end
            frame_o      <= step && x_wrap && y_wrap;
            cursor_rst_o <= sync_go;
            if (sync_go) begin
                stall_cpu_o <= 1'b0;
            end else if (wsync_i) begin
                stall_cpu_o <= 1'b1;
            end else if (step && (x_q == H_REL9)) begin
                stall_cpu_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tia_beam_ctrl.sv
// Bench for tia_beam_ctrl on a shrunken beam geometry so whole frames fit
// in a short run. A behavioural model predicts every output each cycle;
// directed literal checks pin the model at the interesting points.
module tb_tia_beam_ctrl;

    localparam int P_PACE = 3;
    localparam int P_HT   = 40;
    localparam int P_HV   = 24;
    localparam int P_VT   = 30;
    localparam int P_VV   = 26;
    localparam int P_VTOP = 3;
    localparam int P_VBOT = 22;
    localparam int P_HREL = 23;
    localparam int WAIT_LIMIT = 5500;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       wsync_i = 1'b0;
    logic       vsync_i = 1'b0;
    logic       lcd_busy_i = 1'b0;
    logic [8:0] xpos_o, ypos_o, pix_x_o, pix_y_o;
    logic       pix_stb_o, pix_blank_o, cursor_rst_o, frame_o, stall_cpu_o;

    int n_checks = 0;
    int n_errors = 0;

    tia_beam_ctrl #(
        .H_TOTAL  (P_HT),
        .H_VISIBLE(P_HV),
        .V_TOTAL  (P_VT),
        .V_VISIBLE(P_VV),
        .V_TOP    (P_VTOP),
        .V_BOTTOM (P_VBOT),
        .PACE     (8'(P_PACE)),
        .HREL_X   (P_HREL)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wsync_i     (wsync_i),
        .vsync_i     (vsync_i),
        .lcd_busy_i  (lcd_busy_i),
        .xpos_o      (xpos_o),
        .ypos_o      (ypos_o),
        .pix_x_o     (pix_x_o),
        .pix_y_o     (pix_y_o),
        .pix_stb_o   (pix_stb_o),
        .pix_blank_o (pix_blank_o),
        .cursor_rst_o(cursor_rst_o),
        .frame_o     (frame_o),
        .stall_cpu_o (stall_cpu_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = waiting for LCD after reset, 1 = restart cycle, 2 = running
    // age: cycles spent running since the last step or restart
    int m_phase = 0;
    int m_age   = 0;
    int ex = 0, ey = 0, e_px = 0, e_py = 0;
    int e_stb = 0, e_blank = 0, e_cur = 0, e_frame = 0, e_stall = 0;

    always @(posedge clk_i or negedge rst_ni) begin : model
        int nx, ny, nage, nph, nstall, stb, bl, fr, cur, npx, npy;
        if (!rst_ni) begin
            m_phase <= 0; m_age <= 0; ex <= 0; ey <= 0; e_px <= 0; e_py <= 0;
            e_stb <= 0; e_blank <= 0; e_cur <= 0; e_frame <= 0; e_stall <= 0;
        end else begin
            nx = ex; ny = ey; nage = m_age; nph = m_phase; nstall = e_stall;
            stb = 0; bl = 0; fr = 0; cur = 0; npx = e_px; npy = e_py;
            if (vsync_i && m_phase != 1) begin
                nx = 0; ny = 0; nage = 0; nstall = 0; cur = 1; nph = 1;
            end else begin
                if (m_phase == 0) begin
                    if (!lcd_busy_i) nph = 2;
                end else if (m_phase == 1) begin
                    nph = 2;
                end else if (m_age >= P_PACE && !lcd_busy_i) begin
                    if (ex < P_HV && ey < P_VV) begin
                        stb = 1; npx = ex; npy = ey;
                        bl = (ey < P_VTOP || ey >= P_VBOT) ? 1 : 0;
                    end
                    if (ex == P_HREL) nstall = 0;
                    if (ex == P_HT - 1) begin
                        nx = 0;
                        if (ey == P_VT - 1) begin ny = 0; fr = 1; end
                        else ny = ey + 1;
                    end else begin
                        nx = ex + 1;
                    end
                    nage = 0;
                end else begin
                    nage = m_age + 1;
                end
                if (wsync_i) nstall = 1;
            end
            m_phase <= nph; m_age <= nage; ex <= nx; ey <= ny; e_px <= npx; e_py <= npy;
            e_stb <= stb; e_blank <= bl; e_cur <= cur; e_frame <= fr; e_stall <= nstall;
        end
    end

    // Compare every cycle, half a clock away from the active edge
    always @(negedge clk_i) begin
        check("xpos", int'(xpos_o), ex);
        check("ypos", int'(ypos_o), ey);
        check("pix_stb", int'(pix_stb_o), e_stb);
        check("pix_x", int'(pix_x_o), e_px);
        check("pix_y", int'(pix_y_o), e_py);
        if (e_stb != 0) check("pix_blank", int'(pix_blank_o), e_blank);
        check("cursor_rst", int'(cursor_rst_o), e_cur);
        check("frame", int'(frame_o), e_frame);
        check("stall", int'(stall_cpu_o), e_stall);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_xy(input int tx, input int ty);
        int n;
        n = 0;
        while (!(int'(xpos_o) == tx && int'(ypos_o) == ty) && n < WAIT_LIMIT) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= WAIT_LIMIT) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_xy timeout: beam at %0d/%0d, expected to reach %0d/%0d",
                     xpos_o, ypos_o, tx, ty);
        end
    endtask

    initial begin
        tick(3);
        check("lit_rst_x", int'(xpos_o), 0);
        check("lit_rst_stall", int'(stall_cpu_o), 0);
        check("lit_rst_stb", int'(pix_stb_o), 0);
        rst_ni = 1'b1;

        // first step after release, then steady spacing
        repeat (4) @(posedge clk_i);
        #1 check("lit_pre_step_x", int'(xpos_o), 0);
        check("lit_pre_step_stb", int'(pix_stb_o), 0);
        @(posedge clk_i);
        #1 check("lit_step1_x", int'(xpos_o), 1);
        check("lit_step1_stb", int'(pix_stb_o), 1);
        check("lit_step1_px", int'(pix_x_o), 0);
        check("lit_step1_py", int'(pix_y_o), 0);
        check("lit_step1_blank", int'(pix_blank_o), 1);
        @(posedge clk_i);
        #1 check("lit_stb_pulse", int'(pix_stb_o), 0);
        repeat (2) @(posedge clk_i);
        #1 check("lit_step2_early_x", int'(xpos_o), 1);
        @(posedge clk_i);
        #1 check("lit_step2_x", int'(xpos_o), 2);
        check("lit_step2_px", int'(pix_x_o), 1);
        @(negedge clk_i);

        // WSYNC mid-line, released leaving HREL_X
        wait_xy(10, 0);
        wsync_i = 1'b1; tick(1); wsync_i = 1'b0;
        check("lit_wsync_set", int'(stall_cpu_o), 1);
        wait_xy(24, 0);
        check("lit_wsync_rel", int'(stall_cpu_o), 0);

        // WSYNC coinciding with the releasing step: held through next line
        wait_xy(23, 1);
        tick(3);
        wsync_i = 1'b1; tick(1); wsync_i = 1'b0;
        check("lit_coinc_x", int'(xpos_o), 24);
        check("lit_coinc_stall", int'(stall_cpu_o), 1);
        wait_xy(35, 1);
        check("lit_coinc_hold", int'(stall_cpu_o), 1);

        // blanking edges
        wait_xy(1, 2);
        check("lit_top_stb", int'(pix_stb_o), 1);
        check("lit_top_py", int'(pix_y_o), 2);
        check("lit_top_blank", int'(pix_blank_o), 1);
        check("lit_coinc_hold2", int'(stall_cpu_o), 1);
        wait_xy(24, 2);
        check("lit_coinc_rel", int'(stall_cpu_o), 0);
        wait_xy(1, 3);
        check("lit_vtop_stb", int'(pix_stb_o), 1);
        check("lit_vtop_blank", int'(pix_blank_o), 0);

        // last visible x and first invisible x
        wait_xy(24, 5);
        check("lit_xlast_stb", int'(pix_stb_o), 1);
        check("lit_xlast_px", int'(pix_x_o), 23);
        check("lit_xlast_blank", int'(pix_blank_o), 0);
        wait_xy(25, 5);
        check("lit_xhv_stb", int'(pix_stb_o), 0);

        // line wrap
        wait_xy(39, 10);
        tick(4);
        check("lit_hwrap_x", int'(xpos_o), 0);
        check("lit_hwrap_y", int'(ypos_o), 11);
        check("lit_hwrap_stb", int'(pix_stb_o), 0);

        wait_xy(1, 22);
        check("lit_vbot_stb", int'(pix_stb_o), 1);
        check("lit_vbot_blank", int'(pix_blank_o), 1);
        wait_xy(1, 26);
        check("lit_vvis_stb", int'(pix_stb_o), 0);

        // frame wrap
        wait_xy(39, 29);
        tick(4);
        check("lit_fwrap_x", int'(xpos_o), 0);
        check("lit_fwrap_y", int'(ypos_o), 0);
        check("lit_fwrap_frame", int'(frame_o), 1);

        // VSYNC (with a WSYNC) on a step cycle while stalled
        wait_xy(10, 5);
        wsync_i = 1'b1; tick(1); wsync_i = 1'b0;
        wait_xy(20, 5);
        tick(3);
        check("lit_vs_pre_stall", int'(stall_cpu_o), 1);
        wsync_i = 1'b1; vsync_i = 1'b1; tick(1); wsync_i = 1'b0; vsync_i = 1'b0;
        check("lit_vs_x", int'(xpos_o), 0);
        check("lit_vs_y", int'(ypos_o), 0);
        check("lit_vs_cursor", int'(cursor_rst_o), 1);
        check("lit_vs_stall", int'(stall_cpu_o), 0);
        check("lit_vs_stb", int'(pix_stb_o), 0);
        tick(1);
        check("lit_vs_cursor_pulse", int'(cursor_rst_o), 0);
        tick(3);
        check("lit_vs_nostep_x", int'(xpos_o), 0);
        tick(1);
        check("lit_vs_step_x", int'(xpos_o), 1);

        // LCD busy across a step point
        wait_xy(5, 0);
        tick(1);
        lcd_busy_i = 1'b1;
        tick(20);
        check("lit_busy_hold_x", int'(xpos_o), 5);
        check("lit_busy_stb", int'(pix_stb_o), 0);
        lcd_busy_i = 1'b0;
        tick(1);
        check("lit_busy_step_x", int'(xpos_o), 6);
        check("lit_busy_step_stb", int'(pix_stb_o), 1);

        // reset with a strobe in flight
        wait_xy(8, 0);
        check("lit_inflight_stb", int'(pix_stb_o), 1);
        #2 rst_ni = 1'b0;
        #1 check("lit_arst_stb", int'(pix_stb_o), 0);
        check("lit_arst_x", int'(xpos_o), 0);
        check("lit_arst_px", int'(pix_x_o), 0);
        tick(3);
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 check("lit_rerun_stb", int'(pix_stb_o), 0);
        @(posedge clk_i);
        #1 check("lit_rerun_x", int'(xpos_o), 1);
        check("lit_rerun_stb2", int'(pix_stb_o), 1);
        check("lit_rerun_px", int'(pix_x_o), 0);
        tick(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tia_beam_ctrl.md
# tia_beam_ctrl

Beam scheduler for the Atari 2600 TIA video path. It owns the horizontal and vertical beam counters that race the ILI9341 LCD like a CRT. It paces pixel writes against the LCD writer's busy flag and decides when each pixel is strobed and whether it is blanked. It also sequences the WSYNC CPU stall and VSYNC frame restart, so the TIA register block only decodes writes and computes pixel colour from the coordinates this block presents.

## Interface
- `H_TOTAL`, 456: beam steps per line (228 colour clocks x 2).
- `H_VISIBLE`, 320: steps per line that produce LCD pixels.
- `V_TOTAL`, 262: lines per frame.
- `V_VISIBLE`, 240: lines that produce LCD pixels.
- `V_TOP`, 24: first non-blanked visible line.
- `V_BOTTOM`, 226: first blanked line after the picture.
- `PACE`, 255: idle cycles between beam steps (8-bit, must be ≥1).
- `HREL_X`, 319: stall is released on the step leaving this x.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `wsync_i`  in  1  one-cycle pulse on a WSYNC register write.
- `vsync_i`  in  1  one-cycle pulse on a VSYNC write with D1=1.
- `lcd_busy_i`  in  1  LCD writer busy; no step may occur while high.
- `xpos_o`  out  9  live beam x.
- `ypos_o`  out  9  live beam y.
- `pix_x_o`  out  9  x of the pixel being strobed.
- `pix_y_o`  out  9  y of the pixel being strobed.
- `pix_stb_o`  out  1  one-cycle pixel write request.
- `pix_blank_o`  out  1  with `pix_stb_o`: write black instead of the colour.
- `cursor_rst_o`  out  1  one-cycle LCD cursor reset.
- `frame_o`  out  1  one-cycle pulse on frame wrap.
- `stall_cpu_o`  out  1  holds the 6502 (WSYNC).

## Operation
- FSM states:
  - INIT: entered on reset. Moves to RUN on the first cycle with `lcd_busy_i` low.
  - RUN: normal beam pacing.
  - SYNC: entered from INIT or RUN when `vsync_i`=1. Lasts exactly one cycle, then returns to RUN.
- `pace_cnt` (8-bit):
  - Counts up in RUN, saturating at `PACE`.
  - Cleared to 0 on every step and on entering SYNC.
  - Holds in INIT.
- Step condition: state RUN, `pace_cnt`==`PACE`, `lcd_busy_i`=0, `vsync_i`=0.
- Step actions, using pre-step x/y:
  - Pixel output: if x<`H_VISIBLE` and y<`V_VISIBLE`, then next cycle `pix_stb_o`=1, `pix_x_o`/`pix_y_o` = x/y, and `pix_blank_o` = (y<`V_TOP` || y≥`V_BOTTOM`).
  - x counter: x = x+1, or 0 if x==`H_TOTAL`-1.
  - y counter: on x wrap, y = y+1, or 0 if y==`V_TOTAL`-1; the y wrap also pulses `frame_o`.
  - Stall release: if x==`HREL_X`, clear the stall.
- Stall:
  - `wsync_i` sets `stall_cpu_o`.
  - A step leaving `HREL_X` clears it, and so does entering SYNC.
  - When set and clear coincide, set wins; the stall then lasts until the next line's release.
- VSYNC:
  - `vsync_i` has priority over a step in the same cycle.
  - Next cycle: x=y=0, `pace_cnt`=0, `cursor_rst_o`=1, stall cleared, no `pix_stb_o`.
  - `wsync_i` coinciding with `vsync_i` is ignored.
- Widths: x/y are 9-bit unsigned and every compare is unsigned. `pix_x_o`/`pix_y_o` hold their values between strobes.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state INIT, `pace_cnt`=0.
- Step spacing: with the LCD idle, the first step occurs `PACE`+1 cycles after RUN is entered, and steps recur every `PACE`+1 cycles. `pix_stb_o` lags its step by one cycle.
- LCD busy: if busy is high when `pace_cnt` reaches `PACE`, the step waits and fires on the first cycle with busy low.
- Output updates:
  - `stall_cpu_o` rises the cycle after `wsync_i` and falls the cycle after the releasing step.
  - `cursor_rst_o` and `frame_o` are single-cycle pulses.
- Reset asserted mid-operation: all outputs return to 0 immediately, including strobes and pulses in flight; no pending pixel is strobed after reset releases.
- `lcd_busy_i` high in SYNC is ignored.

## Test plan
- Reset, then release with busy low and `PACE`=3 -> INIT→RUN; first step on cycle 5 after release, `pix_stb_o` on cycle 6 with pix_x/y=0/0 and `pix_blank_o`=1; steps every 4 cycles thereafter.
- Force x=455, y=10, then step -> x=0, y=11, no strobe. Force x=455, y=261 -> x=0, y=0, `frame_o` pulse.
- Pixels at y=23, y=24, y=226 and x=319 / x=320 on y=100 -> strobes for y=23 (blank=1), y=24 (blank=0), y=226 (blank=1), x=319 (blank=0); no strobe at x=320.
- `wsync_i` at x=100 -> stall high until the step from x=319 to 320. `wsync_i` in the same cycle as that step -> stall held for the full next line.
- `vsync_i` at x=200, y=50, stalled, in the same cycle as a step -> no step and no strobe; x=y=0, `cursor_rst_o`=1, stall=0 one cycle later; next step `PACE`+2 cycles after `vsync_i`.
- Hold `lcd_busy_i` high for 20 cycles across a step point -> `pace_cnt` holds at `PACE`; the step fires the cycle busy falls, and no strobe is issued while busy is high.
